// File: rtl/layer_compositor.sv
// Two-stage pixel compositor: priority-merges NUM_LAYERS flagged layers with override and
// background, and reports per-frame layer overlaps on collision_flags.
module layer_compositor #(
   parameter int          NUM_LAYERS = 8,
   parameter int          COLOR_W    = 8,
   parameter logic [23:0] BG_COLOR   = 24'h000000,
   localparam int         PIX_W      = 3 * COLOR_W,
   localparam int         IDX_W      = $clog2(NUM_LAYERS)
) (
   input  logic                        pixel_clk,
   input  logic                        rst_n,
   input  logic                        fsync,
   input  logic                        active_in,
   input  logic [NUM_LAYERS-1:0]       layer_active,
   input  logic [NUM_LAYERS*PIX_W-1:0] layer_pixel,
   input  logic [NUM_LAYERS-1:0]       layer_enable,
   input  logic                        override_en,
   input  logic [PIX_W-1:0]            override_pix,
   output logic [PIX_W-1:0]            pixel_out,
   output logic                        active_out,
   output logic                        fsync_out,
   output logic [IDX_W-1:0]            winner_idx,
   output logic                        winner_valid,
   output logic [NUM_LAYERS-1:0]       collision_flags
);

   localparam logic [PIX_W-1:0] BG_PIX = PIX_W'(BG_COLOR);

   logic [NUM_LAYERS-1:0] s1_m;
   logic [PIX_W-1:0]      s1_pix [NUM_LAYERS];
   logic                  s1_ovr_en;
   logic [PIX_W-1:0]      s1_ovr_pix;
   logic                  s1_active;
   logic                  s1_fsync;

   logic [NUM_LAYERS-1:0] acc;
   logic [NUM_LAYERS-1:0] contrib;

   logic                  win_found;
   logic [IDX_W-1:0]      win_idx;
   logic [PIX_W-1:0]      nxt_pix;
   logic                  nxt_valid;
   logic [IDX_W-1:0]      nxt_idx;

   // Stage 1: qualify layer flags and capture everything the output stage needs.
   // NOTE: the per-layer pixel array is a handful of pipeline flops, not a RAM, so it is reset
   // with the rest of the pipeline to guarantee clean outputs after rst_n.
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_m       <= '0;
         s1_ovr_en  <= 1'b0;
         s1_ovr_pix <= '0;
         s1_active  <= 1'b0;
         s1_fsync   <= 1'b0;
         for (int i = 0; i < NUM_LAYERS; i++) s1_pix[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         s1_m       <= layer_active & layer_enable & {NUM_LAYERS{active_in}};
         s1_ovr_en  <= override_en;
         s1_ovr_pix <= override_pix;
         s1_active  <= active_in;
         s1_fsync   <= fsync;
         for (int i = 0; i < NUM_LAYERS; i++) s1_pix[i] <= layer_pixel[i*PIX_W +: PIX_W];
      end
   end

   // Lowest set index wins; scanning downward lets the last hit be the highest priority.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (s1_m[i]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      nxt_pix   = '0;
      nxt_valid = 1'b0;
      nxt_idx   = '0;
      if (!s1_active) begin
         nxt_pix = '0;
      end else if (s1_ovr_en) begin
         nxt_pix = s1_ovr_pix;
      end else if (win_found) begin
         nxt_pix   = s1_pix[win_idx];
         nxt_valid = 1'b1;
         nxt_idx   = win_idx;
      end else begin
         nxt_pix = BG_PIX;
      end
   end

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         pixel_out    <= '0;
         active_out   <= 1'b0;
         fsync_out    <= 1'b0;
         winner_idx   <= '0;
         winner_valid <= 1'b0;
      end else begin
         pixel_out    <= nxt_pix;
         active_out   <= s1_active;
         fsync_out    <= s1_fsync;
         winner_idx   <= nxt_idx;
         winner_valid <= nxt_valid;
      end
   end

   // m & (m-1) is nonzero exactly when two or more layers overlap at this pixel.
   assign contrib = (|(s1_m & (s1_m - NUM_LAYERS'(1)))) ? s1_m : '0;

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         acc             <= '0;
         collision_flags <= '0;
      end else if (s1_fsync) begin
         collision_flags <= acc | contrib;
         acc             <= '0;
      end else begin
         acc             <= acc | contrib;
      end
   end

endmodule
